xbar_slave_arbiter: RTL and testbench
=====================================

# xbar_slave_arbiter

Per-slave arbitration and response-routing stage for the next-generation cross bar. One instance sits in front of each slave port and is parametrised in master count, bus widths, arbitration mode and outstanding-read depth. It selects one requesting master, forwards that master's command to the slave, and returns the slave's acknowledge to the winner. Read responses are routed back in issue order through an internal ID FIFO, so several reads can be outstanding at once.

## Interface
Parameters:
- MASTER_N, 4: number of masters arbitrated (≥2)
- ADDR_W, 32: address width
- DATA_W, 32: data width
- RESP_DEPTH, 4: max outstanding reads (power of two, ≥2)
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- m_req  in  MASTER_N  per-master request already decoded for this slave
- m_addr  in  MASTER_N*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- m_cmd  in  MASTER_N  1 = write, 0 = read
- m_wdata  in  MASTER_N*DATA_W  packed write data
- m_ack  out  MASTER_N  one-hot acknowledge to the granted master
- m_resp  out  MASTER_N  one-hot read-response strobe
- m_rdata  out  DATA_W  read data, valid with any m_resp bit
- s_req  out  1  request to slave
- s_addr  out  ADDR_W  address to slave
- s_cmd  out  1  command to slave
- s_wdata  out  DATA_W  write data to slave
- s_ack  in  1  slave accepted current request
- s_resp  in  1  slave read-response strobe
- s_rdata  in  DATA_W  slave read data
- outstanding  out  $clog2(RESP_DEPTH)+1  reads issued but not yet answered
- err  out  1  sticky: s_resp received with no outstanding read

## Operation
- FSM states: IDLE, BUSY.
- IDLE: eligible = m_req, with read requesters (m_cmd=0) masked when the FIFO is full. If eligible ≠ 0, register winner index `gnt` and go to BUSY; otherwise stay.
- Round-robin: search from `ptr` upward, wrapping modulo MASTER_N. On each s_ack, `ptr` ← (gnt+1) mod MASTER_N. Reset ptr = 0.
- Fixed priority: lowest eligible index wins; ptr is unused.
- BUSY: s_req=1 and s_addr/s_cmd/s_wdata = the fields of master gnt, driven from live inputs. The grant is locked until s_ack, even if m_req[gnt] drops; masters hold their request fields stable until m_ack.
- BUSY with s_ack=1: m_ack[gnt]=1 in the same cycle. If the command is a read, push gnt into the FIFO. Return to IDLE.
- Response path: s_resp=1 with FIFO non-empty gives m_resp[head]=1 and m_rdata=s_rdata in the same cycle, and pops the FIFO. s_resp=1 with FIFO empty sets err; nothing is popped and no m_resp is raised. err clears only on rst.
- A push and a pop in the same cycle leave outstanding unchanged. Both FIFO pointers wrap modulo RESP_DEPTH.
- Writes are never blocked by a full FIFO and never produce m_resp.
- m_rdata = s_rdata at all times (combinational pass-through).

## Timing
- Reset values: state IDLE, gnt 0, ptr 0, FIFO empty, outstanding 0, err 0, s_req 0, m_ack 0, m_resp 0. s_addr/s_cmd/s_wdata are 0 in IDLE.
- Latency: m_req seen in IDLE at cycle N gives s_req=1 at cycle N+1.
- Acknowledge: m_ack is combinational from s_ack, with zero added latency.
- Throughput: at most one accepted transaction every 2 cycles (BUSY→IDLE→BUSY).
- Response: m_resp is combinational from s_resp. outstanding updates on the next edge after push or pop.
- Full FIFO: a read requester is not granted until a pop has registered (earliest the cycle after the popping s_resp).
- Reset mid-operation: all state is cleared, and in-flight requests and outstanding reads are discarded. A late s_resp after reset sets err.

## Test plan
- Round-robin fairness: ARB_MODE=0, m_req=4'b1111 held, all writes, s_ack=1 whenever s_req=1 → grant order 0,1,2,3,0 and m_ack one-hot on successive BUSY cycles.
- Fixed priority: ARB_MODE=1, m_req=4'b1010 held → master 1 wins every time; after master 1 drops its request, master 3 is granted.
- Outstanding reads in order: masters 2,0,3 issue reads and are acked; then 3 s_resp pulses with s_rdata=0xA,0xB,0xC → m_resp to masters 2,0,3 carrying 0xA,0xB,0xC; outstanding steps 1,2,3,2,1,0.
- FIFO full: RESP_DEPTH=4, with 4 reads outstanding, master 1 reads and master 2 writes → master 2 is granted and master 1 is not. After one s_resp, master 1 is granted no earlier than the following cycle.
- Simultaneous push and pop: s_ack for a read in the same cycle as s_resp → outstanding unchanged and m_resp goes to the FIFO head, not the new read.
- Errors and reset: s_resp with outstanding=0 → err=1, all m_resp=0. Assert rst while in BUSY → next cycle s_req=0, outstanding=0, err=0.

Source files
------------

// File: rtl/xbar_slave_arbiter_if.sv
// Bus bundle between the masters, one per-slave arbiter and its slave port.
// The arbiter uses the slave modport; the environment (masters plus slave
// model) uses the master modport.
interface xbar_slave_arbiter_if #(
  parameter int MASTER_N   = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RESP_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(RESP_DEPTH) + 1;

  logic [MASTER_N-1:0]        m_req;
  logic [MASTER_N*ADDR_W-1:0] m_addr;
  logic [MASTER_N-1:0]        m_cmd;
  logic [MASTER_N*DATA_W-1:0] m_wdata;
  logic [MASTER_N-1:0]        m_ack;
  logic [MASTER_N-1:0]        m_resp;
  logic [DATA_W-1:0]          m_rdata;
  logic                       s_req;
  logic [ADDR_W-1:0]          s_addr;
  logic                       s_cmd;
  logic [DATA_W-1:0]          s_wdata;
  logic                       s_ack;
  logic                       s_resp;
  logic [DATA_W-1:0]          s_rdata;
  logic [CNT_W-1:0]           outstanding;
  logic                       err;

  modport slave (
    input  m_req, m_addr, m_cmd, m_wdata, s_ack, s_resp, s_rdata,
    output m_ack, m_resp, m_rdata, s_req, s_addr, s_cmd, s_wdata, outstanding, err
  );

  modport master (
    output m_req, m_addr, m_cmd, m_wdata, s_ack, s_resp, s_rdata,
    input  m_ack, m_resp, m_rdata, s_req, s_addr, s_cmd, s_wdata, outstanding, err
  );
endinterface

// File: rtl/xbar_slave_arbiter.sv
// Per-slave arbiter for the crossbar: picks one requesting master, forwards
// its command to the slave, returns the acknowledge to the winner and routes
// read responses back in issue order through a small ID FIFO.
module xbar_slave_arbiter #(
  parameter int MASTER_N   = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RESP_DEPTH = 4,
  parameter int ARB_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  xbar_slave_arbiter_if.slave   bus
);
  localparam int IDX_W = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [MASTER_N-1:0] ONE_M = {{(MASTER_N-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_gnt;
  logic [IDX_W-1:0]    w_gnt_nxt;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    w_ptr_nxt;
  logic [IDX_W-1:0]    w_gnt_inc;
  logic [IDX_W-1:0]    r_fifo [RESP_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_err;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_err_set;
  logic [MASTER_N-1:0] w_eligible;
  logic                w_found;
  logic [IDX_W-1:0]    w_pick;
  int                  w_idx;

  // Reads may only be granted while there is room to remember who issued them.
  always_comb begin
    w_full  = (r_count == CNT_W'(RESP_DEPTH));
    w_empty = (r_count == {CNT_W{1'b0}});
    if (w_full) begin
      w_eligible = bus.m_req & bus.m_cmd;
    end else begin
      w_eligible = bus.m_req;
    end
    w_gnt_inc = (r_gnt == IDX_W'(MASTER_N - 1)) ? {IDX_W{1'b0}} : (r_gnt + IDX_W'(1));
  end

  // Winner search: rotating start point in round-robin, index 0 first otherwise.
  always_comb begin
    w_found = 1'b0;
    w_pick  = {IDX_W{1'b0}};
    w_idx   = 0;
    for (int k = 0; k < MASTER_N; k++) begin
      if (ARB_MODE == 0) begin
        w_idx = int'(r_ptr) + k;
        if (w_idx >= MASTER_N) begin
          w_idx = w_idx - MASTER_N;
        end else begin
          w_idx = w_idx;
        end
      end else begin
        w_idx = k;
      end
      if (!w_found && w_eligible[w_idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(w_idx);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Next-state logic and slave-side outputs; the grant is held until s_ack.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_push      = 1'b0;
    bus.s_req   = 1'b0;
    bus.s_addr  = {ADDR_W{1'b0}};
    bus.s_cmd   = 1'b0;
    bus.s_wdata = {DATA_W{1'b0}};
    bus.m_ack   = {MASTER_N{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_BUSY;
          w_gnt_nxt   = w_pick;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        bus.s_req   = 1'b1;
        bus.s_addr  = bus.m_addr[r_gnt*ADDR_W +: ADDR_W];
        bus.s_cmd   = bus.m_cmd[r_gnt];
        bus.s_wdata = bus.m_wdata[r_gnt*DATA_W +: DATA_W];
        if (bus.s_ack) begin
          bus.m_ack   = ONE_M << r_gnt;
          w_push      = ~bus.m_cmd[r_gnt];
          w_ptr_nxt   = w_gnt_inc;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Response routing: the FIFO head owns the next read response.
  always_comb begin
    w_pop       = bus.s_resp & ~w_empty;
    w_err_set   = bus.s_resp & w_empty;
    bus.m_rdata = bus.s_rdata;
    if (w_pop) begin
      bus.m_resp = ONE_M << r_fifo[r_rd_ptr];
    end else begin
      bus.m_resp = {MASTER_N{1'b0}};
    end
    bus.outstanding = r_count;
    bus.err         = r_err;
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= {IDX_W{1'b0}};
      r_ptr   <= {IDX_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Read-ID FIFO, outstanding counter and sticky unexpected-response flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        r_fifo[i] <= {IDX_W{1'b0}};
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_gnt;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_err <= r_err | w_err_set;
    end
  end
endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Bench for xbar_slave_arbiter: a round-robin instance driven by directed and
// random traffic against a transaction-level model, plus a fixed-priority
// instance exercised directly.
module tb_xbar_slave_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xbar_slave_arbiter_if #(.MASTER_N(N), .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(D)) bus_rr ();
  xbar_slave_arbiter_if #(.MASTER_N(N), .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(D)) bus_fp ();

  xbar_slave_arbiter #(.MASTER_N(N), .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(D), .ARB_MODE(0))
    dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
  xbar_slave_arbiter #(.MASTER_N(N), .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(D), .ARB_MODE(1))
    dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  int checks = 0;
  int errors = 0;

  // master-side pending transactions
  logic [N-1:0]  p_req;
  logic [N-1:0]  p_cmd;
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_wdata [N];

  // stimulus policy
  int            rearm_mode;   // 0 none, 1 always write, 2 random
  int            ack_pct;
  int            resp_mode;    // 0 none, 1 random, 2 one forced pulse
  logic [DW-1:0] force_rdata;
  logic          drive_rst;

  // reference model
  bit mdl_busy;
  int mdl_gnt;
  int mdl_ptr;
  bit mdl_err;
  int rdq[$];
  int glog[$];

  // last observed outputs
  logic          last_s_req;
  logic [AW-1:0] last_s_addr;
  logic [N-1:0]  last_m_ack;
  logic [N-1:0]  last_m_resp;
  logic [DW-1:0] last_m_rdata;
  logic [2:0]    last_out;
  logic          last_err;

  function automatic int pick_winner(logic [N-1:0] elig, int ptr);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) begin
        d = (i - ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic new_txn(int m, logic cmd);
    p_req[m]   = 1'b1;
    p_cmd[m]   = cmd;
    p_addr[m]  = $urandom;
    p_wdata[m] = $urandom;
  endtask

  task automatic model_clear();
    mdl_busy = 1'b0;
    mdl_gnt  = 0;
    mdl_ptr  = 0;
    mdl_err  = 1'b0;
    rdq.delete();
    p_req    = '0;
  endtask

  // One clock of the round-robin instance: drive, check, advance the model.
  task automatic cycle();
    logic          s_ack_v;
    logic          s_resp_v;
    logic [DW-1:0] rd_v;
    logic [N-1:0]  exp_ack;
    logic [N-1:0]  exp_resp;
    logic [N-1:0]  elig;
    logic [N-1:0]  one;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          exp_cmd;
    int            qsz;
    int            w;
    one = {{(N-1){1'b0}}, 1'b1};
    @(posedge clk);
    #1;
    rst = drive_rst;
    bus_rr.m_req = p_req;
    bus_rr.m_cmd = p_cmd;
    for (int i = 0; i < N; i++) begin
      bus_rr.m_addr[i*AW +: AW]  = p_addr[i];
      bus_rr.m_wdata[i*DW +: DW] = p_wdata[i];
    end
    s_ack_v  = mdl_busy && ($urandom_range(99, 0) < ack_pct);
    s_resp_v = 1'b0;
    rd_v     = $urandom;
    if (resp_mode == 1) begin
      s_resp_v = (rdq.size() > 0) && ($urandom_range(99, 0) < 40);
    end else if (resp_mode == 2) begin
      s_resp_v  = 1'b1;
      rd_v      = force_rdata;
      resp_mode = 0;
    end
    bus_rr.s_ack   = s_ack_v;
    bus_rr.s_resp  = s_resp_v;
    bus_rr.s_rdata = rd_v;
    #1;
    last_s_req   = bus_rr.s_req;
    last_s_addr  = bus_rr.s_addr;
    last_m_ack   = bus_rr.m_ack;
    last_m_resp  = bus_rr.m_resp;
    last_m_rdata = bus_rr.m_rdata;
    last_out     = bus_rr.outstanding;
    last_err     = bus_rr.err;

    exp_ack   = s_ack_v ? (one << mdl_gnt) : '0;
    exp_resp  = (s_resp_v && rdq.size() > 0) ? (one << rdq[0]) : '0;
    exp_addr  = mdl_busy ? p_addr[mdl_gnt] : '0;
    exp_wdata = mdl_busy ? p_wdata[mdl_gnt] : '0;
    exp_cmd   = mdl_busy ? p_cmd[mdl_gnt] : 1'b0;

    checks++;
    if (bus_rr.s_req !== mdl_busy) begin
      errors++; $display("FAIL s_req: got %b expected %b at %0t", bus_rr.s_req, mdl_busy, $time);
    end
    checks++;
    if (bus_rr.s_addr !== exp_addr || bus_rr.s_cmd !== exp_cmd || bus_rr.s_wdata !== exp_wdata) begin
      errors++; $display("FAIL s_fields: got %h/%b/%h expected %h/%b/%h at %0t",
        bus_rr.s_addr, bus_rr.s_cmd, bus_rr.s_wdata, exp_addr, exp_cmd, exp_wdata, $time);
    end
    checks++;
    if (bus_rr.m_ack !== exp_ack) begin
      errors++; $display("FAIL m_ack: got %b expected %b at %0t", bus_rr.m_ack, exp_ack, $time);
    end
    checks++;
    if (bus_rr.m_resp !== exp_resp || bus_rr.m_rdata !== rd_v) begin
      errors++; $display("FAIL m_resp: got %b/%h expected %b/%h at %0t",
        bus_rr.m_resp, bus_rr.m_rdata, exp_resp, rd_v, $time);
    end
    checks++;
    if (bus_rr.outstanding !== 3'(rdq.size()) || bus_rr.err !== mdl_err) begin
      errors++; $display("FAIL outstanding_err: got %0d/%b expected %0d/%b at %0t",
        bus_rr.outstanding, bus_rr.err, rdq.size(), mdl_err, $time);
    end

    qsz = rdq.size();
    if (drive_rst) begin
      model_clear();
    end else begin
      if (s_resp_v) begin
        if (qsz > 0) void'(rdq.pop_front());
        else mdl_err = 1'b1;
      end
      if (mdl_busy) begin
        if (s_ack_v) begin
          if (!p_cmd[mdl_gnt]) rdq.push_back(mdl_gnt);
          mdl_ptr = (mdl_gnt + 1) % N;
          glog.push_back(mdl_gnt);
          p_req[mdl_gnt] = 1'b0;
          mdl_busy = 1'b0;
        end
      end else begin
        elig = (qsz < D) ? p_req : (p_req & p_cmd);
        w = pick_winner(elig, mdl_ptr);
        if (w >= 0) begin
          mdl_busy = 1'b1;
          mdl_gnt  = w;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!p_req[i]) begin
          if (rearm_mode == 1) new_txn(i, 1'b1);
          else if (rearm_mode == 2 && $urandom_range(99, 0) < 30) new_txn(i, 1'($urandom_range(1, 0)));
        end
      end
    end
  endtask

  task automatic do_reset();
    rearm_mode = 0;
    ack_pct    = 100;
    resp_mode  = 0;
    drive_rst  = 1'b1;
    cycle();
    drive_rst  = 1'b0;
  endtask

  task automatic issue_read(int m);
    int guard;
    guard = 0;
    new_txn(m, 1'b0);
    while (p_req[m] && guard < 20) begin
      cycle();
      guard++;
    end
    cycle();
  endtask

  task automatic test_reset();
    cycle();
    checks++;
    if (last_s_req !== 1'b0 || last_m_ack !== 4'b0000 || last_m_resp !== 4'b0000 ||
        last_out !== 3'd0 || last_err !== 1'b0 || last_s_addr !== 32'h0) begin
      errors++; $display("FAIL reset_state: got req=%b ack=%b resp=%b out=%0d err=%b addr=%h",
        last_s_req, last_m_ack, last_m_resp, last_out, last_err, last_s_addr);
    end
    repeat (2) cycle();
  endtask

  task automatic test_round_robin();
    int exp_order [5];
    do_reset();
    exp_order = '{0, 1, 2, 3, 0};
    rearm_mode = 1;
    for (int i = 0; i < N; i++) new_txn(i, 1'b1);
    glog.delete();
    repeat (12) cycle();
    rearm_mode = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (glog.size() <= i) begin
        errors++; $display("FAIL rr_order[%0d]: got no grant expected %0d", i, exp_order[i]);
      end else if (glog[i] != exp_order[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, glog[i], exp_order[i]);
      end
    end
    repeat (3) cycle();
  endtask

  task automatic test_fixed_priority();
    bus_fp.m_cmd = '1;
    bus_fp.s_ack = 1'b1;
    for (int i = 0; i < N; i++) bus_fp.m_addr[i*AW +: AW] = 32'h100 * i;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      bus_fp.m_req = 4'b1010;
      #1;
      checks++;
      if (bus_fp.s_req !== 1'b0 || bus_fp.m_ack !== 4'b0000) begin
        errors++; $display("FAIL fp_idle: got req=%b ack=%b expected 0/0000", bus_fp.s_req, bus_fp.m_ack);
      end
      @(posedge clk); #2;
      checks++;
      if (bus_fp.s_req !== 1'b1 || bus_fp.s_addr !== 32'h100 || bus_fp.m_ack !== 4'b0010) begin
        errors++; $display("FAIL fp_m1: got req=%b addr=%h ack=%b expected 1/00000100/0010",
          bus_fp.s_req, bus_fp.s_addr, bus_fp.m_ack);
      end
    end
    @(posedge clk); #1;
    bus_fp.m_req = 4'b1000;
    @(posedge clk); #2;
    checks++;
    if (bus_fp.s_addr !== 32'h300 || bus_fp.m_ack !== 4'b1000) begin
      errors++; $display("FAIL fp_m3: got addr=%h ack=%b expected 00000300/1000", bus_fp.s_addr, bus_fp.m_ack);
    end
    @(posedge clk); #1;
    bus_fp.m_req = '0;
    bus_fp.s_ack = 1'b0;
  endtask

  task automatic test_in_order_reads();
    logic [N-1:0]  exp_r [3];
    logic [DW-1:0] exp_d [3];
    logic [2:0]    exp_o [3];
    do_reset();
    exp_r = '{4'b0100, 4'b0001, 4'b1000};
    exp_d = '{32'hA, 32'hB, 32'hC};
    exp_o = '{3'd3, 3'd2, 3'd1};
    issue_read(2);
    checks++; if (last_out !== 3'd1) begin errors++; $display("FAIL rd_out1: got %0d expected 1", last_out); end
    issue_read(0);
    checks++; if (last_out !== 3'd2) begin errors++; $display("FAIL rd_out2: got %0d expected 2", last_out); end
    issue_read(3);
    checks++; if (last_out !== 3'd3) begin errors++; $display("FAIL rd_out3: got %0d expected 3", last_out); end
    for (int i = 0; i < 3; i++) begin
      force_rdata = exp_d[i];
      resp_mode   = 2;
      cycle();
      checks++;
      if (last_m_resp !== exp_r[i] || last_m_rdata !== exp_d[i] || last_out !== exp_o[i]) begin
        errors++; $display("FAIL rd_resp[%0d]: got %b/%h/%0d expected %b/%h/%0d", i,
          last_m_resp, last_m_rdata, last_out, exp_r[i], exp_d[i], exp_o[i]);
      end
    end
    cycle();
    checks++; if (last_out !== 3'd0) begin errors++; $display("FAIL rd_out0: got %0d expected 0", last_out); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int m = 0; m < N; m++) issue_read(m);
    checks++; if (last_out !== 3'd4) begin errors++; $display("FAIL full_out: got %0d expected 4", last_out); end
    new_txn(1, 1'b0);
    new_txn(2, 1'b1);
    cycle();
    cycle();
    checks++;
    if (last_m_ack !== 4'b0100) begin errors++; $display("FAIL full_write_ack: got %b expected 0100", last_m_ack); end
    force_rdata = 32'h1234;
    resp_mode   = 2;
    cycle();
    checks++;
    if (last_s_req !== 1'b0 || last_m_resp !== 4'b0001) begin
      errors++; $display("FAIL full_pop: got req=%b resp=%b expected 0/0001", last_s_req, last_m_resp);
    end
    cycle();
    checks++;
    if (last_s_req !== 1'b0) begin errors++; $display("FAIL full_early: got req=%b expected 0", last_s_req); end
    cycle();
    checks++;
    if (last_s_req !== 1'b1 || last_s_addr !== p_addr[1]) begin
      errors++; $display("FAIL full_late_grant: got req=%b addr=%h expected 1/%h", last_s_req, last_s_addr, p_addr[1]);
    end
    repeat (2) cycle();
  endtask

  task automatic test_push_pop();
    do_reset();
    issue_read(0);
    new_txn(1, 1'b0);
    cycle();
    force_rdata = 32'h55;
    resp_mode   = 2;
    cycle();
    checks++;
    if (last_m_resp !== 4'b0001 || last_m_ack !== 4'b0010 || last_out !== 3'd1) begin
      errors++; $display("FAIL pushpop: got resp=%b ack=%b out=%0d expected 0001/0010/1",
        last_m_resp, last_m_ack, last_out);
    end
    cycle();
    checks++; if (last_out !== 3'd1) begin errors++; $display("FAIL pushpop_out: got %0d expected 1", last_out); end
  endtask

  task automatic test_err_reset();
    do_reset();
    force_rdata = 32'h77;
    resp_mode   = 2;
    cycle();
    checks++; if (last_m_resp !== 4'b0000) begin errors++; $display("FAIL err_noresp: got %b expected 0000", last_m_resp); end
    cycle();
    checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", last_err); end
    issue_read(3);
    ack_pct = 0;
    new_txn(1, 1'b0);
    cycle();
    cycle();
    checks++; if (last_s_req !== 1'b1) begin errors++; $display("FAIL busy_before_rst: got %b expected 1", last_s_req); end
    do_reset();
    cycle();
    checks++;
    if (last_s_req !== 1'b0 || last_out !== 3'd0 || last_err !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got req=%b out=%0d err=%b expected 0/0/0", last_s_req, last_out, last_err);
    end
    resp_mode = 2;
    cycle();
    cycle();
    checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL late_resp_err: got %b expected 1", last_err); end
  endtask

  task automatic test_random();
    do_reset();
    rearm_mode = 2;
    ack_pct    = 60;
    resp_mode  = 1;
    repeat (400) cycle();
    rearm_mode = 0;
    resp_mode  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    p_req = '0; p_cmd = '0;
    for (int i = 0; i < N; i++) begin p_addr[i] = '0; p_wdata[i] = '0; end
    rearm_mode = 0; ack_pct = 100; resp_mode = 0; force_rdata = '0; drive_rst = 1'b0;
    bus_rr.m_req = '0; bus_rr.m_addr = '0; bus_rr.m_cmd = '0; bus_rr.m_wdata = '0;
    bus_rr.s_ack = 1'b0; bus_rr.s_resp = 1'b0; bus_rr.s_rdata = '0;
    bus_fp.m_req = '0; bus_fp.m_addr = '0; bus_fp.m_cmd = '0; bus_fp.m_wdata = '0;
    bus_fp.s_ack = 1'b0; bus_fp.s_resp = 1'b0; bus_fp.s_rdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    model_clear();
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_in_order_reads();
    test_fifo_full();
    test_push_pop();
    test_err_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
